// File: rtl/axi_ram_resp.sv
// AXI4 subordinate RAM: independent single-outstanding write and read engines
// sharing one byte-strobed word array.
module axi_ram_resp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,

    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,

    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,

    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,

    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int SIZE_MAX = $clog2(STRB_WIDTH);
    localparam int WORD_AW  = ADDR_WIDTH - SIZE_MAX;
    localparam int DEPTH    = 2 ** WORD_AW;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic                  incr;
        logic                  err;
    } burst_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic burst_t capture(input logic [ID_WIDTH-1:0]   id,
                                       input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [7:0]            len,
                                       input logic [2:0]            size,
                                       input logic [1:0]            burst);
        burst_t b;
        b.id   = id;
        b.addr = addr;
        b.len  = len;
        b.size = size;
        b.incr = (burst == 2'b01);
        // WRAP and the reserved encoding both have bit 1 set
        b.err  = burst[1] || (size > 3'(SIZE_MAX));
        return b;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] step(input burst_t b);
        return b.incr ? b.addr + (ADDR_WIDTH'(1) << b.size) : b.addr;
    endfunction

    function automatic logic [WORD_AW-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1:SIZE_MAX];
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Holds both ready outputs low through the reset cycle itself.
    logic run;

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // Burst length comes from awlen alone; wlast carries no information here.
    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_wlast};

    w_state_t w_state, w_state_next;
    burst_t   w_cur;
    logic [7:0] w_cnt;
    logic aw_hs, w_hs, b_hs;

    assign s_axi_awready = run && (w_state == W_IDLE);
    assign s_axi_wready  = (w_state == W_DATA);
    assign s_axi_bvalid  = (w_state == W_RESP);
    assign s_axi_bid     = w_cur.id;
    assign s_axi_bresp   = {w_cur.err, 1'b0};

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid  && s_axi_wready;
    assign b_hs  = s_axi_bvalid  && s_axi_bready;

    always_comb begin
        // NOTE: next state defaults to the current state first, so no path leaves it unassigned and no latch is inferred.
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_next = W_DATA;
            W_DATA:  if (w_hs && (w_cnt == w_cur.len)) w_state_next = W_RESP;
            W_RESP:  if (b_hs) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_cur   <= '0;
            w_cnt   <= '0;
        end else begin
            w_state <= w_state_next;
            if (aw_hs) begin
                w_cur <= capture(s_axi_awid, s_axi_awaddr, s_axi_awlen,
                                 s_axi_awsize, s_axi_awburst);
                w_cnt <= '0;
            end else if (w_hs) begin
                w_cur.addr <= step(w_cur);
                w_cnt      <= w_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately outside reset; reset must leave contents intact and a reset would block RAM inference.
        if (rst_n && w_hs && !w_cur.err) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_axi_wstrb[i])
                    mem[word_of(w_cur.addr)][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
            end
        end
    end

    r_state_t r_state, r_state_next;
    burst_t   r_cur, r_fetch;
    logic [7:0] r_cnt;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic rlast_q, r_load;
    logic ar_hs, r_hs;

    assign s_axi_arready = run && (r_state == R_IDLE);
    assign s_axi_rvalid  = (r_state == R_DATA);
    assign s_axi_rid     = r_cur.id;
    assign s_axi_rresp   = {r_cur.err, 1'b0};
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rlast   = rlast_q;

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid  && s_axi_rready;

    // r_fetch is the burst state after this edge; r_load means a new beat is fetched.
    always_comb begin
        r_state_next = r_state;
        r_fetch      = r_cur;
        r_load       = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_next = R_DATA;
                    r_fetch      = capture(s_axi_arid, s_axi_araddr, s_axi_arlen,
                                           s_axi_arsize, s_axi_arburst);
                    r_load       = 1'b1;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rlast_q) begin
                        r_state_next = R_IDLE;
                    end else begin
                        r_fetch.addr = step(r_cur);
                        r_load       = 1'b1;
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // The array read samples pre-edge contents, so a same-cycle write is not seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_cur   <= '0;
            r_cnt   <= '0;
            rdata_q <= '0;
            rlast_q <= 1'b0;
        end else begin
            r_state <= r_state_next;
            if (r_load) begin
                r_cur   <= r_fetch;
                r_cnt   <= ar_hs ? 8'd0 : r_cnt + 8'd1;
                rdata_q <= r_fetch.err ? '0 : mem[word_of(r_fetch.addr)];
                rlast_q <= ar_hs ? (r_fetch.len == 8'd0)
                                 : ((r_cnt + 8'd1) == r_cur.len);
            end else if (r_hs) begin
                rlast_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axi_ram_resp.md
AXI_RAM_RESP -- requirements
Module: axi_ram_resp

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits; 8, 16, 32, 64 or 128 only.
REQ-002 Parameter ADDR_WIDTH, default 16, byte address width; memory depth is 2^ADDR_WIDTH bytes.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8, write strobe width.
REQ-004 Parameter ID_WIDTH, default 8, transaction ID width.
REQ-005 Port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1, reset; synchronous, active-low.
REQ-007 AW inputs: s_axi_awid[ID_WIDTH], s_axi_awaddr[ADDR_WIDTH], s_axi_awlen[8], s_axi_awsize[3], s_axi_awburst[2], s_axi_awvalid[1]; output s_axi_awready[1].
REQ-008 W inputs: s_axi_wdata[DATA_WIDTH], s_axi_wstrb[STRB_WIDTH], s_axi_wlast[1], s_axi_wvalid[1]; output s_axi_wready[1].
REQ-009 B outputs: s_axi_bid[ID_WIDTH], s_axi_bresp[2], s_axi_bvalid[1]; input s_axi_bready[1].
REQ-010 AR inputs: s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid (widths as AW); output s_axi_arready[1].
REQ-011 R outputs: s_axi_rid[ID_WIDTH], s_axi_rdata[DATA_WIDTH], s_axi_rresp[2], s_axi_rlast[1], s_axi_rvalid[1]; input s_axi_rready[1].
REQ-012 No lock/cache/prot/qos/region/user ports; the block is an AXI4 subordinate (responder) for an AXI4 manager.

Function
REQ-013 Storage: internal word array of 2^ADDR_WIDTH/STRB_WIDTH words, indexed by addr[ADDR_WIDTH-1:log2(STRB_WIDTH)]; no initialisation.
REQ-014 Write FSM states W_IDLE, W_DATA, W_RESP; read FSM states R_IDLE, R_DATA; the two FSMs are independent, one outstanding transaction each.
REQ-015 W_IDLE: awready=1; on awvalid&awready capture id/addr/len/size/burst, clear beat counter, go W_DATA.
REQ-016 W_DATA: wready=1; each wvalid&wready beat writes wdata bytes whose wstrb bit is 1 (error bursts write nothing); counter increments; beat with counter==len goes to W_RESP.
REQ-017 Burst termination uses the captured len only; wlast is ignored.
REQ-018 Address step: INCR (01) adds 1<<size after each beat, FIXED (00) holds; address wraps modulo 2^ADDR_WIDTH; no 4 KB boundary check.
REQ-019 Error burst: burst WRAP (10) or reserved (11), or size > log2(STRB_WIDTH); still consumes len+1 beats; bresp/rresp=SLVERR (10), rdata=0; otherwise OKAY (00).
REQ-020 W_RESP: bvalid=1, bid=captured id; hold stable until bready; on handshake go W_IDLE (awready=1 the next cycle).
REQ-021 R_IDLE: arready=1; on arvalid&arready capture fields, go R_DATA; rvalid=1 the next cycle with beat 0 data.
REQ-022 R_DATA: rid=captured id, rlast=1 only when counter==len; rdata/rresp/rlast held stable while rvalid&!rready; with rready held high one beat per cycle.
REQ-023 On handshake of rlast beat go R_IDLE; rvalid=0 and arready=1 the next cycle.
REQ-024 Same-word read and write in the same cycle: read returns the pre-write contents.
REQ-025 Latency: AW handshake cycle N -> wready at N+1; last W beat at M -> bvalid at M+1; AR handshake at N -> first rvalid at N+1.

Reset
REQ-026 While rst_n=0 at a clock edge: FSMs to W_IDLE/R_IDLE; awready, wready, bvalid, arready, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0.
REQ-027 Memory contents are not altered by reset; reset mid-burst abandons the burst with no response.
REQ-028 First clock after rst_n rises: awready=1, arready=1.

Verification
REQ-029 Single write addr 0x0010, len 0, size 2, INCR, data 0xDEADBEEF, strb 0xF, id 0x5A -> bresp 00, bid 0x5A; read back same -> rdata 0xDEADBEEF, rlast 1, rid 0x5A.
REQ-030 INCR write len 3 at 0x0100 data 1..4, strb 0x3 on beat 2 -> read len 3 returns 1, 2, old upper bytes|0x0003, 4; rlast only on beat 3.
REQ-031 FIXED write len 2 at 0x0200 data A,B,C -> single word 0x0200 holds C; word 0x0204 unchanged.
REQ-032 WRAP burst len 1 -> two W beats accepted, bresp 10, memory unchanged; WRAP read len 1 -> two beats rresp 10, rdata 0.
REQ-033 Backpressure: random bready/rready deassertion -> B/R payload stable while valid&!ready; concurrent read/write bursts complete independently.
REQ-034 rst_n=0 for one cycle mid write burst -> outputs per REQ-026, awready=1 next cycle, earlier-written beats retained.
